// File: rtl/count_down_timer_n.sv
// count_down_timer_n
// Prescaled countdown timer with pause and abort, a one-cycle done pulse and a
// seven-segment units digit. It has one clock and a synchronous active-low reset.
// Optional feature macro: CDT_AUTO_RELOAD_EN. When it is defined, the count reloads
// the start value on the final tick and keeps running until it is aborted.
module count_down_timer_n #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 100000000
) (
  input  logic             Clk100M,
  input  logic             resetN,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] loadValue,
  output logic             doneCounting,
  output logic             busy,
  output logic [WIDTH-1:0] curCount,
  output logic [7:0]       seg
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t          state, next_state;
  logic [PW-1:0]   presc, next_presc;
  logic [WIDTH-1:0] next_count;
  logic            next_done;
  logic [7:0]      next_seg;
`ifdef CDT_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload, next_reload;
`endif

  // Active-low {dp,g,f,e,d,c,b,a} pattern for one decimal digit; dp always off.
  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // The modulo is done at 32 bits so that a narrow WIDTH never truncates the constant 10.
  function automatic logic [3:0] units_of(input logic [WIDTH-1:0] v);
    return 4'(32'(v) % 32'd10);
  endfunction

  // Register all state. The reset is synchronous, so it is sampled only on the clock edge.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, whatever the statement order.
  // NOTE: the reload value is an ordinary register, not a memory, so it is
  // reset together with the rest.
  always_ff @(posedge Clk100M) begin
    if (!resetN) begin
      state        <= S_IDLE;
      presc        <= '0;
      curCount     <= '0;
      doneCounting <= 1'b0;
      seg          <= 8'hFF;
`ifdef CDT_AUTO_RELOAD_EN
      reload       <= '0;
`endif
    end else begin
      state        <= next_state;
      presc        <= next_presc;
      curCount     <= next_count;
      doneCounting <= next_done;
      seg          <= next_seg;
`ifdef CDT_AUTO_RELOAD_EN
      reload       <= next_reload;
`endif
    end
  end

  // Next-state logic. The priority order is abort, then start, then pause, then the prescaler tick.
  // NOTE: every output of this block gets its default value first, so no latch can be inferred.
  always_comb begin
    next_state  = state;
    next_presc  = presc;
    next_count  = curCount;
    next_done   = 1'b0;
`ifdef CDT_AUTO_RELOAD_EN
    next_reload = reload;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          if (loadValue != '0) begin
            next_count = loadValue;
            next_presc = '0;
            next_state = S_RUN;
`ifdef CDT_AUTO_RELOAD_EN
            next_reload = loadValue;
`endif
          end else begin
            next_done = 1'b1;
          end
        end
      end
      S_RUN, S_PAUSE: begin
        if (abort) begin
          next_state = S_IDLE;
          next_count = '0;
          next_presc = '0;
        end else if (pause) begin
          next_state = S_PAUSE;
        end else begin
          // Leaving PAUSE also counts this cycle, so a pause cycle delays the count by exactly one cycle.
          next_state = S_RUN;
          if (presc == TICK_LAST) begin
            next_presc = '0;
            if (curCount > WIDTH'(1)) begin
              next_count = curCount - WIDTH'(1);
            end else begin
              next_done = 1'b1;
`ifdef CDT_AUTO_RELOAD_EN
              next_count = reload;
`else
              next_count = '0;
              next_state = S_IDLE;
`endif
            end
          end else begin
            next_presc = presc + PW'(1);
          end
        end
      end
      default: begin
        next_state = S_IDLE;
        next_count = '0;
        next_presc = '0;
      end
    endcase

    // The segment register follows next_count, so seg and curCount change on the same edge.
    if (next_state != S_IDLE) begin
      next_seg = seg_digit(units_of(next_count));
    end else if (next_done) begin
      next_seg = 8'hC0;
    end else begin
      next_seg = 8'hFF;
    end
  end

  assign busy = (state != S_IDLE);

endmodule
